// File: rtl/world_mem_ctrl.sv
// world_mem_ctrl: write-port controller for the snake world memory.
// After reset or clear_req it sweeps the grid to empty, seeds the initial
// snake and food cells, then round-robin arbitrates the single write port
// between the snake engine and the food spawner.
// Optional build macro: WORLD_VBLANK_GATE_EN (adds vblank input; IDLE grants
// are only issued while vblank=1).
module world_mem_ctrl #(
  parameter int GRID      = 15,
  parameter int SNAKE_LEN = 3,
  parameter int FOOD_X    = 3,
  parameter int FOOD_Y    = 3
) (
  input  logic       clk,
  input  logic       rst,
`ifdef WORLD_VBLANK_GATE_EN
  input  logic       vblank,
`endif
  input  logic       clear_req,
  input  logic       snake_req,
  input  logic [3:0] snake_x,
  input  logic [3:0] snake_y,
  input  logic [1:0] snake_data,
  output logic       snake_ack,
  input  logic       food_req,
  input  logic [3:0] food_x,
  input  logic [3:0] food_y,
  input  logic [1:0] food_data,
  output logic       food_ack,
  output logic       mem_we,
  output logic [3:0] mem_x,
  output logic [3:0] mem_y,
  output logic [1:0] mem_data,
  output logic       busy,
  output logic       init_done,
  output logic       coord_err
);

  localparam logic [3:0] GRID_C      = 4'(GRID);
  localparam logic [3:0] SNAKE_LEN_C = 4'(SNAKE_LEN);
  localparam logic [3:0] FOOD_X_C    = 4'(FOOD_X);
  localparam logic [3:0] FOOD_Y_C    = 4'(FOOD_Y);

  localparam logic SRC_SNAKE = 1'b0;
  localparam logic SRC_FOOD  = 1'b1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_SEED  = 2'd1,
    ST_IDLE  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // A location is writable only if both coordinates lie in 1..GRID.
  function automatic logic coord_ok(input logic [3:0] x, input logic [3:0] y);
    return (x != 4'd0) && (x <= GRID_C) && (y != 4'd0) && (y <= GRID_C);
  endfunction

  state_t     state_r, state_s;
  logic [3:0] cnt_x_r, cnt_x_s;
  logic [3:0] cnt_y_r, cnt_y_s;
  logic [3:0] seed_idx_r, seed_idx_s;
  logic       rr_last_r, rr_last_s;
  logic       win_r, win_s;
  logic [3:0] lat_x_r, lat_x_s;
  logic [3:0] lat_y_r, lat_y_s;
  logic [1:0] lat_data_r, lat_data_s;

  logic       mem_we_r, mem_we_s;
  logic [3:0] mem_x_r, mem_x_s;
  logic [3:0] mem_y_r, mem_y_s;
  logic [1:0] mem_data_r, mem_data_s;
  logic       snake_ack_r, snake_ack_s;
  logic       food_ack_r, food_ack_s;
  logic       busy_r, busy_s;
  logic       init_done_r, init_done_s;
  logic       coord_err_r, coord_err_s;

  logic       grant_ok_s;
  logic       pick_food_s;

  // Grant qualifier: with the gate built in, game writes wait for vertical blank.
`ifdef WORLD_VBLANK_GATE_EN
  always_comb grant_ok_s = vblank;
`else
  always_comb grant_ok_s = 1'b1;
`endif

  // Next-state, datapath and next-output logic for the sweep/seed/arbiter FSM.
  always_comb begin
    state_s     = state_r;
    cnt_x_s     = cnt_x_r;
    cnt_y_s     = cnt_y_r;
    seed_idx_s  = seed_idx_r;
    rr_last_s   = rr_last_r;
    win_s       = win_r;
    lat_x_s     = lat_x_r;
    lat_y_s     = lat_y_r;
    lat_data_s  = lat_data_r;
    mem_we_s    = 1'b0;
    mem_x_s     = 4'd0;
    mem_y_s     = 4'd0;
    mem_data_s  = 2'b00;
    snake_ack_s = 1'b0;
    food_ack_s  = 1'b0;
    coord_err_s = 1'b0;
    busy_s      = (state_r != ST_IDLE);
    init_done_s = 1'b0;
    // Food wins when it is the only requester, or when both ask and snake went last.
    pick_food_s = food_req && (!snake_req || (rr_last_r == SRC_SNAKE));

    case (state_r)
      ST_CLEAR: begin
        mem_we_s   = 1'b1;
        mem_x_s    = cnt_x_r;
        mem_y_s    = cnt_y_r;
        mem_data_s = 2'b00;
        if (cnt_x_r == GRID_C) begin
          cnt_x_s = 4'd1;
          if (cnt_y_r == GRID_C) begin
            cnt_y_s    = 4'd1;
            seed_idx_s = 4'd0;
            state_s    = ST_SEED;
          end else begin
            cnt_y_s = cnt_y_r + 4'd1;
          end
        end else begin
          cnt_x_s = cnt_x_r + 4'd1;
        end
      end

      ST_SEED: begin
        mem_we_s = 1'b1;
        if (seed_idx_r < SNAKE_LEN_C) begin
          mem_x_s    = seed_idx_r + 4'd1;
          mem_y_s    = 4'd1;
          mem_data_s = 2'b10;
          seed_idx_s = seed_idx_r + 4'd1;
        end else begin
          mem_x_s    = FOOD_X_C;
          mem_y_s    = FOOD_Y_C;
          mem_data_s = 2'b01;
          seed_idx_s = 4'd0;
          state_s    = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (clear_req) begin
          init_done_s = 1'b0;
          cnt_x_s     = 4'd1;
          cnt_y_s     = 4'd1;
          state_s     = ST_CLEAR;
        end else begin
          init_done_s = 1'b1;
          if (grant_ok_s && (snake_req || food_req)) begin
            state_s = ST_WRITE;
            if (pick_food_s) begin
              win_s      = SRC_FOOD;
              lat_x_s    = food_x;
              lat_y_s    = food_y;
              lat_data_s = food_data;
            end else begin
              win_s      = SRC_SNAKE;
              lat_x_s    = snake_x;
              lat_y_s    = snake_y;
              lat_data_s = snake_data;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
      end

      ST_WRITE: begin
        init_done_s = 1'b1;
        snake_ack_s = (win_r == SRC_SNAKE);
        food_ack_s  = (win_r == SRC_FOOD);
        rr_last_s   = win_r;
        state_s     = ST_IDLE;
        if (coord_ok(lat_x_r, lat_y_r)) begin
          mem_we_s   = 1'b1;
          mem_x_s    = lat_x_r;
          mem_y_s    = lat_y_r;
          mem_data_s = lat_data_r;
        end else begin
          coord_err_s = 1'b1;
        end
      end

      default: begin
        cnt_x_s = 4'd1;
        cnt_y_s = 4'd1;
        state_s = ST_CLEAR;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset restarts the sweep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_CLEAR;
      cnt_x_r     <= 4'd1;
      cnt_y_r     <= 4'd1;
      seed_idx_r  <= 4'd0;
      rr_last_r   <= SRC_FOOD;
      win_r       <= SRC_SNAKE;
      lat_x_r     <= 4'd0;
      lat_y_r     <= 4'd0;
      lat_data_r  <= 2'b00;
      mem_we_r    <= 1'b0;
      mem_x_r     <= 4'd0;
      mem_y_r     <= 4'd0;
      mem_data_r  <= 2'b00;
      snake_ack_r <= 1'b0;
      food_ack_r  <= 1'b0;
      busy_r      <= 1'b0;
      init_done_r <= 1'b0;
      coord_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_x_r     <= cnt_x_s;
      cnt_y_r     <= cnt_y_s;
      seed_idx_r  <= seed_idx_s;
      rr_last_r   <= rr_last_s;
      win_r       <= win_s;
      lat_x_r     <= lat_x_s;
      lat_y_r     <= lat_y_s;
      lat_data_r  <= lat_data_s;
      mem_we_r    <= mem_we_s;
      mem_x_r     <= mem_x_s;
      mem_y_r     <= mem_y_s;
      mem_data_r  <= mem_data_s;
      snake_ack_r <= snake_ack_s;
      food_ack_r  <= food_ack_s;
      busy_r      <= busy_s;
      init_done_r <= init_done_s;
      coord_err_r <= coord_err_s;
    end
  end

  assign mem_we    = mem_we_r;
  assign mem_x     = mem_x_r;
  assign mem_y     = mem_y_r;
  assign mem_data  = mem_data_r;
  assign snake_ack = snake_ack_r;
  assign food_ack  = food_ack_r;
  assign busy      = busy_r;
  assign init_done = init_done_r;
  assign coord_err = coord_err_r;

endmodule

// File: doc/world_mem_ctrl.md
Name: world_mem_ctrl

Overview:
- Write-port controller for the 15x15 snake world memory.
- After reset, or on request, sweeps the whole grid to empty (00) and then seeds the initial snake and food cells.
- After seeding, round-robin arbitrates the single write port between the snake engine and the food spawner.
- Drives the memory's write-side location, data and write-enable; the VGA read side is untouched.

Parameters:
- GRID, 15: grid edge length in cells; coordinates are 1-based, 1..GRID; GRID must be at most 15.
- SNAKE_LEN, 3: initial snake length; cells (1,1)..(SNAKE_LEN,1) are written with 10.
- FOOD_X, 3: initial food x coordinate.
- FOOD_Y, 3: initial food y coordinate; cell (FOOD_X,FOOD_Y) is written with 01.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- clear_req  in  1  level request to re-clear and re-seed the grid.
- snake_req  in  1  snake engine write request; held until snake_ack.
- snake_x, snake_y  in  4 each  snake write coordinates, 1-based.
- snake_data  in  2  snake cell value.
- snake_ack  out  1  one-cycle grant/complete pulse to the snake engine.
- food_req  in  1  food spawner write request; held until food_ack.
- food_x, food_y  in  4 each  food write coordinates, 1-based.
- food_data  in  2  food cell value.
- food_ack  out  1  one-cycle grant/complete pulse to the food spawner.
- mem_we  out  1  memory write enable.
- mem_x, mem_y  out  4 each  memory write location.
- mem_data  out  2  memory write data.
- busy  out  1  high in any state other than IDLE.
- init_done  out  1  high once seeding has completed; low during CLEAR and SEED.
- coord_err  out  1  one-cycle pulse when a granted write is out of range.

Behaviour:
- All outputs are registered.
- While rst=0: state=CLEAR, sweep counter=(1,1), rr_last=food (so snake has first priority), all outputs 0.
- CLEAR: one write per cycle with mem_we=1, mem_data=00 at the counter location.
  - x advances 1..GRID, then wraps to 1 and y increments.
  - After (GRID,GRID) is written (GRID*GRID cycles, 225 by default), go to SEED.
- SEED: SNAKE_LEN+1 consecutive writes, one per cycle:
  - snake cells (1,1), (2,1), (3,1) with 10;
  - then food cell (FOOD_X,FOOD_Y) with 01;
  - then go to IDLE.
  - init_done is set on the cycle after the last seed write; 229 cycles total from reset release by default.
- IDLE: mem_we=0.
  - clear_req=1: go to CLEAR and reset the counter. clear_req has priority over pending requests, which wait.
  - Otherwise, if exactly one request is high, grant it.
  - If both are high, grant the requester other than rr_last.
  - Latch the winner's x, y and data, then go to WRITE.
- WRITE (1 cycle):
  - Drive the latched values with mem_we=1; pulse the winner's ack; update rr_last; return to IDLE.
  - Sustained throughput is one write per 2 cycles.
  - A requester may keep req high for back-to-back writes; with both requesters active, grants strictly alternate.
- Out-of-range coordinate (x or y equal to 0 or greater than GRID): the ack still pulses, mem_we stays 0, and coord_err pulses in the WRITE cycle.
- clear_req during CLEAR or SEED is ignored; the sweep is not restarted.
- A request arriving during CLEAR or SEED waits until IDLE.
- rst=0 at any point aborts immediately; the next edge after release starts CLEAR from (1,1).
- Coordinate arithmetic is 4-bit unsigned; the counter never exceeds GRID.

Optional Feature:
- Macro: WORLD_VBLANK_GATE_EN.
- When defined:
  - Adds input port vblank (1 bit).
  - Grants from IDLE occur only when vblank=1, so the display never sees mid-frame game updates.
  - CLEAR and SEED are not gated.
  - A clear_req while vblank=0 is still accepted.
- When undefined: the port is absent and grants are ungated, exactly as described in Behaviour.

Test Plan:
- Release rst: mem_we is high for exactly 229 consecutive cycles.
  - First write is (1,1) with 00; write 225 is (15,15) with 00.
  - Then (1,1), (2,1), (3,1) with 10, then (3,3) with 01.
  - init_done rises next cycle; busy falls.
- In IDLE, snake_req with (5,7) and data 10: two cycles later mem_we=1, mem_x=5, mem_y=7, mem_data=10, snake_ack pulses once.
- snake_req and food_req both held high for 8 cycles: grants alternate snake, food, snake, food; 4 acks in total, each ack aligned with its mem_we.
- food_req with (0,4), then (16 mod 16 = 0, 2), then (15,15): the first two give food_ack with coord_err and mem_we=0; the third writes normally.
- clear_req asserted the same cycle as snake_req in IDLE: CLEAR runs for 225 cycles, then SEED; snake_ack arrives only after init_done=1.
- rst pulled low at sweep cycle 100 and released: CLEAR restarts at (1,1) and the full 229-cycle sequence repeats.
- With WORLD_VBLANK_GATE_EN defined and vblank=0: no ack until vblank rises; the grant then follows within 2 cycles.
